// File: rtl/ahb3lite_ram_ctrl_if.sv
// ---------------------------------------------------------------------------
// ahb3lite_ram_ctrl_if
//   AHB3-Lite slave-side bus bundle for ahb3lite_ram_ctrl.
//
//   Signals (master view):
//     HSEL       out  Slave select
//     HADDR      out  Byte address               [HADDR_SIZE]
//     HWDATA     out  Write data (data phase)     [HDATA_SIZE]
//     HWRITE     out  1 = write, 0 = read
//     HSIZE      out  Transfer size               [3]
//     HBURST     out  Burst type                  [3]
//     HPROT      out  Protection                  [4]
//     HTRANS     out  IDLE/BUSY/NONSEQ/SEQ        [2]
//     HREADY     out  Bus ready (address phase accepted when 1)
//     HRDATA     in   Read data                   [HDATA_SIZE]
//     HREADYOUT  in   Slave ready
//     HRESP      in   0 = OKAY, 1 = ERROR
// ---------------------------------------------------------------------------
interface ahb3lite_ram_ctrl_if #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
) ();
    logic                  HSEL;
    logic [HADDR_SIZE-1:0] HADDR;
    logic [HDATA_SIZE-1:0] HWDATA;
    logic [HDATA_SIZE-1:0] HRDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb3lite_ram_ctrl.sv
// ---------------------------------------------------------------------------
// ahb3lite_ram_ctrl
//   AHB3-Lite slave front-end for one 1R1W synchronous-read RAM (registered
//   dout, one-cycle read latency). Address phases are decoded into RAM
//   read/write strobes; transfers complete with zero wait states. A write
//   data phase that coincides with a read address phase to the same word is
//   forwarded byte-wise into the following read data phase. Illegal
//   transfers (oversize, misaligned, out of range) get a two-cycle ERROR.
//
//   Parameters:
//     HADDR_SIZE  AHB address width (must exceed MEM_ABITS + log2(HDATA_SIZE/8))
//     HDATA_SIZE  AHB data width, 32 or 64
//     MEM_ABITS   RAM word-address bits
//
//   Ports:
//     HRESETn      in   Asynchronous active-low reset
//     HCLK         in   Clock, rising edge
//     ahb          if   AHB3-Lite slave bundle (ahb3lite_ram_ctrl_if.slave)
//     ram_waddr_o  out  RAM write word address   [MEM_ABITS]
//     ram_din_o    out  RAM write data           [HDATA_SIZE]
//     ram_we_o     out  RAM write enable
//     ram_be_o     out  RAM byte enables         [HDATA_SIZE/8]
//     ram_raddr_o  out  RAM read word address    [MEM_ABITS]
//     ram_dout_i   in   RAM read data, valid one cycle after raddr
// ---------------------------------------------------------------------------
module ahb3lite_ram_ctrl #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int MEM_ABITS  = 10
) (
    input  logic                    HRESETn,
    input  logic                    HCLK,
    ahb3lite_ram_ctrl_if.slave      ahb,
    output logic [MEM_ABITS-1:0]    ram_waddr_o,
    output logic [HDATA_SIZE-1:0]   ram_din_o,
    output logic                    ram_we_o,
    output logic [HDATA_SIZE/8-1:0] ram_be_o,
    output logic [MEM_ABITS-1:0]    ram_raddr_o,
    input  logic [HDATA_SIZE-1:0]   ram_dout_i
);

    localparam int BE_W = HDATA_SIZE / 8;
    localparam int LB   = $clog2(BE_W);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    // ---------------------------------------------------------------
    // Address-phase decode
    // ---------------------------------------------------------------
    logic                 w_accept;
    logic                 w_size_bad;
    logic                 w_misaligned;
    logic                 w_out_of_range;
    logic                 w_legal;
    logic [LB-1:0]        w_offs;
    logic [LB-1:0]        w_align_mask;
    logic [BE_W-1:0]      w_be;
    logic [MEM_ABITS-1:0] w_index;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic                 r_write;
    logic [MEM_ABITS-1:0] r_index;
    logic [BE_W-1:0]      r_be;
    logic [BE_W-1:0]      r_byp_be;
    logic [HDATA_SIZE-1:0] r_byp_data;

    logic                 w_we;
    logic                 w_rd_phase;
    logic [HDATA_SIZE-1:0] w_rdata;

    // ERR1 holds HREADYOUT low, so no address phase is taken there even if
    // the interconnect were to present one.
    assign w_accept = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1] & (r_state != ST_ERR1);

    assign w_offs         = ahb.HADDR[LB-1:0];
    assign w_index        = ahb.HADDR[MEM_ABITS+LB-1:LB];
    assign w_size_bad     = (ahb.HSIZE > 3'(LB));
    assign w_out_of_range = |ahb.HADDR[HADDR_SIZE-1:MEM_ABITS+LB];
    assign w_misaligned   = |(w_offs & w_align_mask);
    assign w_legal        = ~w_size_bad & ~w_misaligned & ~w_out_of_range;

    // Low address bits that must be zero for a transfer of HSIZE.
    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_align_mask = '0;
        for (int i = 0; i < LB; i++) begin
            if (i < int'(ahb.HSIZE)) w_align_mask[i] = 1'b1;
        end
    end

    // 2**HSIZE consecutive byte lanes starting at the byte offset.
    always_comb begin
        w_be = '0;
        for (int b = 0; b < BE_W; b++) begin
            if ((b >= int'(w_offs)) && (b < int'(w_offs) + (1 << int'(ahb.HSIZE))))
                w_be[b] = 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // FSM: IDLE/DATA/ERR2 all accept a new address phase; ERR1 does not.
    // ---------------------------------------------------------------
    always_comb begin
        w_state_next = ST_IDLE;
        if (r_state == ST_ERR1) begin
            w_state_next = ST_ERR2;
        end else if (w_accept) begin
            w_state_next = w_legal ? ST_DATA : ST_ERR1;
        end
    end

    // Data-phase qualifiers derived from the registered address phase.
    assign w_we       = (r_state == ST_DATA) & r_write;
    assign w_rd_phase = (r_state == ST_DATA) & ~r_write;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= ST_IDLE;
            r_write    <= 1'b0;
            r_index    <= '0;
            r_be       <= '0;
            r_byp_be   <= '0;
            r_byp_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_write <= ahb.HWRITE;
                r_index <= w_index;
                r_be    <= w_be;
            end
            // A read address phase overlapping a write data phase to the same
            // word would see stale RAM data (read-before-write); capture the
            // write so the read data phase can substitute the written lanes.
            if (w_accept & w_legal & ~ahb.HWRITE) begin
                r_byp_be   <= (w_we && (r_index == w_index)) ? r_be : '0;
                r_byp_data <= ahb.HWDATA;
            end
        end
    end

    // ---------------------------------------------------------------
    // Read data mux: bypassed lanes from the captured write, rest from RAM.
    // ---------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        if (w_rd_phase) begin
            for (int b = 0; b < BE_W; b++) begin
                w_rdata[8*b +: 8] = r_byp_be[b] ? r_byp_data[8*b +: 8] : ram_dout_i[8*b +: 8];
            end
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign ahb.HRDATA    = w_rdata;
    assign ahb.HREADYOUT = (r_state != ST_ERR1);
    assign ahb.HRESP     = (r_state == ST_ERR1) | (r_state == ST_ERR2);

    // Write strobes are decoded from state, so an asserted reset removes
    // them immediately without waiting for a clock edge.
    assign ram_we_o    = w_we;
    assign ram_waddr_o = r_index;
    assign ram_din_o   = ahb.HWDATA;
    assign ram_be_o    = w_we ? r_be : '0;
    assign ram_raddr_o = w_index;

    // Burst type, protection and the SEQ/NONSEQ distinction do not affect decoding.
    logic w_unused;
    assign w_unused = &{1'b0, ahb.HBURST, ahb.HPROT, ahb.HTRANS[0]};

endmodule
